// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the fetch-stage PC unit.
package pc_pkg;

    localparam int          DEF_XLEN         = 32;
    localparam int          DEF_INC          = 4;
    localparam int          DEF_RAS_DEPTH    = 4;
    localparam longint unsigned DEF_RESET_VECTOR = 64'h0;
    localparam int unsigned ALIGN_MASK       = 32'h3;

    typedef enum logic [2:0] {
        SEL_RST,
        SEL_REDIR,
        SEL_HOLD,
        SEL_CALL,
        SEL_RET,
        SEL_SEQ
    } next_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the fetch stage (master) and the PC unit (slave).
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            write;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            call;
    logic [XLEN-1:0] call_target;
    logic            ret;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_inc;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output write, redirect, redirect_pc, call, call_target, ret,
        input  pc_out, pc_inc, ras_empty, ras_full
    );

    modport slave (
        input  write, redirect, redirect_pc, call, call_target, ret,
        output pc_out, pc_inc, ras_empty, ras_full
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_tos;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_tos_inc;

    assign w_tos_inc = r_tos + 1'b1;
    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_MAX);
    assign top_data  = r_mem[r_tos];

    always_ff @(posedge clk) begin
        if (res) begin
            r_tos   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_tos <= w_tos_inc;
            if (!full) r_count <= r_count + 1'b1;
        end else if (pop && !empty) begin
            r_tos   <= r_tos - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    // Entries are never cleared; only pointer/count reset, so stale data may remain.
    always_ff @(posedge clk) begin
        if (!res && push) r_mem[w_tos_inc] <= push_data;
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with sequential, redirect and call/return next-PC selection.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INC          = DEF_INC,
    parameter int              RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic     clk,
    input  logic     res,
    pc_unit_if.slave bus
);
    localparam logic [XLEN-1:0] ALIGN_KEEP = ~XLEN'(ALIGN_MASK);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_top;
    logic [XLEN-1:0] w_next;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    next_sel_e       w_sel;

    assign w_pc_inc = r_pc + XLEN'(INC);

    always_comb begin
        if (res)                         w_sel = SEL_RST;
        else if (bus.redirect)           w_sel = SEL_REDIR;
        else if (!bus.write)             w_sel = SEL_HOLD;
        else if (bus.call)               w_sel = SEL_CALL;
        else if (bus.ret && !w_empty)    w_sel = SEL_RET;
        else                             w_sel = SEL_SEQ;
    end

    always_comb begin
        w_next = w_pc_inc;
        case (w_sel)
            SEL_RST:   w_next = RESET_VECTOR;
            SEL_REDIR: w_next = bus.redirect_pc;
            SEL_HOLD:  w_next = r_pc;
            SEL_CALL:  w_next = bus.call_target;
            SEL_RET:   w_next = w_top;
            default:   w_next = w_pc_inc;
        endcase
    end

    assign w_push = (w_sel == SEL_CALL);
    assign w_pop  = (w_sel == SEL_RET);

    always_ff @(posedge clk) begin
        r_pc <= w_next & ALIGN_KEEP;
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .res       (res),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign bus.pc_out    = r_pc;
    assign bus.pc_inc    = w_pc_inc;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: queue-based reference model of PC and return stack.
module tb_pc_unit;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INC          (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference model: return stack is a plain queue, oldest entry dropped on overflow.
    task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] rpc,
                        input logic c, input logic [31:0] ct, input logic rt, input string tag);
        @(negedge clk);
        res             = r;
        bus.write       = w;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.call        = c;
        bus.call_target = ct;
        bus.ret         = rt;
        if (r) begin
            m_pc = 32'h0;
            m_ras.delete();
        end else if (rd) begin
            m_pc = rpc & ~32'h3;
        end else if (!w) begin
            m_pc = m_pc;
        end else if (c) begin
            if (m_ras.size() == 4) void'(m_ras.pop_front());
            m_ras.push_back(m_pc + 32'd4);
            m_pc = ct & ~32'h3;
        end else if (rt && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
        end else begin
            m_pc = m_pc + 32'd4;
        end
        sb.push_back('{m_pc, m_ras.size() == 0, m_ras.size() == 4, tag});
    endtask

    task automatic seq(input string tag);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic redir(input logic [31:0] a, input string tag);
        step(1'b0, 1'b1, 1'b1, a, 1'b0, 32'h0, 1'b0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".pc_out"}, bus.pc_out, e.pc);
                check({e.tag, ".pc_inc"}, bus.pc_inc, e.pc + 32'd4);
                check({e.tag, ".ras_empty"}, {31'b0, bus.ras_empty}, {31'b0, e.empty});
                check({e.tag, ".ras_full"}, {31'b0, bus.ras_full}, {31'b0, e.full});
            end
        end
    end

    initial begin : stimulus
        bus.write = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.call = 1'b0; bus.call_target = '0; bus.ret = 1'b0;
        m_pc = '0;

        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset0");
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset1");
        repeat (3) seq("seq_inc");

        redir(32'h10, "to_0x10");
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, "stall_call");

        redir(32'h20, "to_0x20");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, "call_0x100");
        seq("body0");
        seq("body1");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "ret_0x24");

        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset_nest");
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'(4 * i), 1'b0, "nest_call");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "nest_ret");

        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, "call_0x40");
        step(1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b1, "redir_stall_ret");

        redir(32'hFFFF_FFFC, "to_top");
        seq("wrap");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, "call_and_ret");
        step(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, "res_override");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(39) == 0, $urandom_range(7) != 0, $urandom_range(7) == 0,
                 $urandom, $urandom_range(5) == 0, $urandom, $urandom_range(3) == 0, "rand");
        end

        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
